// File: rtl/pwm_multi_channel_if.sv
// Configuration/handshake bundle between the register block and pwm_multi_channel.
// The register-block side uses the master modport; the PWM block uses the slave modport.
interface pwm_multi_channel_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic                 enable;
  logic [CNT_W-1:0]     period;
  logic [PRE_W-1:0]     prescale;
  logic [NCH*CNT_W-1:0] duty;
  logic                 mode;
  logic                 upd_req;
  logic                 upd_busy;
  logic                 period_tick;
  logic [NCH-1:0]       pwm_out;

  modport master (
    output enable, period, prescale, duty, mode, upd_req,
    input  upd_busy, period_tick, pwm_out
  );

  modport slave (
    input  enable, period, prescale, duty, mode, upd_req,
    output upd_busy, period_tick, pwm_out
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared prescaler/period counter and double-buffered configuration.
// Define PWM_CENTER_EN to honour the mode bit (centre-aligned counting); otherwise always edge-aligned.
module pwm_multi_channel #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  pwm_multi_channel_if.slave bus
);

  logic [CNT_W-1:0]     act_period, pend_period, cnt, cnt_nxt;
  logic [PRE_W-1:0]     act_pre, pend_pre, pre_cnt, pre_nxt;
  logic [NCH*CNT_W-1:0] act_duty, pend_duty;
  logic                 busy, step, boundary, apply;
  logic [NCH-1:0]       cmp, pwm_q;
  logic                 tick_q;

`ifdef PWM_CENTER_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t dir, dir_nxt;
  logic act_mode, pend_mode;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  assign step  = bus.enable && (pre_cnt == act_pre);
  // While stopped there is no period to wait for, so updates land immediately.
  assign apply = boundary || !bus.enable;

  always_comb begin
    pre_nxt  = '0;
    cnt_nxt  = cnt;
    boundary = 1'b0;
`ifdef PWM_CENTER_EN
    dir_nxt  = dir;
`endif
    if (!bus.enable) begin
      cnt_nxt = '0;
`ifdef PWM_CENTER_EN
      dir_nxt = DIR_UP;
`endif
    end else begin
      pre_nxt = step ? '0 : pre_cnt + 1'b1;
      if (step) begin
`ifdef PWM_CENTER_EN
        if (act_mode) begin
          // P=1 has no down leg, so the top of the ramp is also the boundary.
          if (act_period == '0) begin
            boundary = 1'b1;
            cnt_nxt  = '0;
          end else if (dir == DIR_DOWN) begin
            if (cnt == CNT_W'(1)) begin
              boundary = 1'b1;
              cnt_nxt  = '0;
              dir_nxt  = DIR_UP;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end else if (cnt == act_period) begin
            if (act_period == CNT_W'(1)) begin
              boundary = 1'b1;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = cnt - 1'b1;
              dir_nxt = DIR_DOWN;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
`else
        begin
`endif
          if (cnt == act_period) begin
            boundary = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cmp = '0;
    for (int i = 0; i < NCH; i++) begin
      cmp[i] = cnt < act_duty[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      pwm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      cnt     <= cnt_nxt;
      pwm_q   <= bus.enable ? cmp : '0;
      tick_q  <= boundary;
    end
  end

`ifdef PWM_CENTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir <= DIR_UP;
    else        dir <= dir_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode  <= 1'b0;
      pend_mode <= 1'b0;
    end else if (bus.upd_req && apply) begin
      act_mode <= bus.mode;
    end else if (bus.upd_req) begin
      pend_mode <= bus.mode;
    end else if (apply && busy) begin
      act_mode <= pend_mode;
    end
  end
`endif

  // A request at an apply point bypasses the pending set; later requests overwrite pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period  <= '0;
      act_pre     <= '0;
      act_duty    <= '0;
      pend_period <= '0;
      pend_pre    <= '0;
      pend_duty   <= '0;
      busy        <= 1'b0;
    end else if (bus.upd_req && apply) begin
      act_period <= bus.period;
      act_pre    <= bus.prescale;
      act_duty   <= bus.duty;
      busy       <= 1'b0;
    end else if (bus.upd_req) begin
      pend_period <= bus.period;
      pend_pre    <= bus.prescale;
      pend_duty   <= bus.duty;
      busy        <= 1'b1;
    end else if (apply && busy) begin
      act_period <= pend_period;
      act_pre    <= pend_pre;
      act_duty   <= pend_duty;
      busy       <= 1'b0;
    end
  end

  assign bus.upd_busy    = busy;
  assign bus.period_tick = tick_q;
  assign bus.pwm_out     = pwm_q;

endmodule
